// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: fetch vs. debug/loader on one single-port memory, 1-cycle response.
// Optional grant/error statistics counters are built when IMEM_ARB_STATS_EN is defined.
module imem_arbiter #(
   parameter int DEPTH        = 128,
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 16
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             fetch_req_i,
   input  logic [31:0]      fetch_addr_i,
   output logic             fetch_gnt_o,
   output logic             fetch_valid_o,
   output logic [31:0]      fetch_inst_o,
   input  logic             dbg_req_i,
   input  logic             dbg_we_i,
   input  logic [31:0]      dbg_addr_i,
   input  logic [31:0]      dbg_wdata_i,
   input  logic             dbg_halt_i,
   output logic             dbg_gnt_o,
   output logic             dbg_valid_o,
   output logic [31:0]      dbg_rdata_o,
   output logic             rsp_err_o,
   output logic             mem_en_o,
   output logic             mem_we_o,
   output logic [31:0]      mem_addr_o,
   output logic [31:0]      mem_wdata_o,
   input  logic [31:0]      mem_rdata_i
`ifdef IMEM_ARB_STATS_EN
   ,
   output logic [CNT_W-1:0] fetch_cnt_o,
   output logic [CNT_W-1:0] dbg_cnt_o,
   output logic [CNT_W-1:0] err_cnt_o
`endif
);

   localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

   localparam logic [1:0] TAG_NONE  = 2'd0;
   localparam logic [1:0] TAG_FETCH = 2'd1;
   localparam logic [1:0] TAG_DBG   = 2'd2;

   logic [SW-1:0] starve_cnt_q, starve_cnt_d;
   logic [1:0]    rsp_tag_q, rsp_tag_d;
   logic          rsp_err_q, rsp_err_d;
   logic          rsp_rd_q, rsp_rd_d;
   logic [31:0]   fetch_hold_q, fetch_hold_d;
   logic [31:0]   dbg_hold_q, dbg_hold_d;

   logic          force_dbg;
   logic          fetch_in_range, dbg_in_range;
   logic          gnt_in_range;

   // Word index is addr[31:2]; low bits are ignored so misaligned addresses are not errors.
   function automatic logic in_range(input logic [31:0] a);
      return a[31:2] < 30'(DEPTH);
   endfunction

   assign fetch_in_range = in_range(fetch_addr_i);
   assign dbg_in_range   = in_range(dbg_addr_i);

   // Arbitration: fetch wins unless debug has been starved long enough or the CPU is halted.
   assign force_dbg   = (starve_cnt_q == SW'(STARVE_LIMIT));
   assign dbg_gnt_o   = ~reset_i & dbg_req_i & (force_dbg | dbg_halt_i | ~fetch_req_i);
   assign fetch_gnt_o = ~reset_i & fetch_req_i & ~dbg_halt_i & ~dbg_gnt_o;

   always_comb begin
      starve_cnt_d = '0;
      if (dbg_req_i && !dbg_gnt_o) begin
         if (starve_cnt_q == SW'(STARVE_LIMIT)) starve_cnt_d = starve_cnt_q;
         else                                   starve_cnt_d = starve_cnt_q + SW'(1);
      end
   end

   // Memory port is driven only by the granted requester, and only for in-range words.
   always_comb begin
      mem_addr_o   = '0;
      mem_wdata_o  = '0;
      mem_we_o     = 1'b0;
      gnt_in_range = 1'b0;
      if (dbg_gnt_o) begin
         mem_addr_o   = dbg_addr_i;
         mem_wdata_o  = dbg_wdata_i;
         gnt_in_range = dbg_in_range;
         mem_we_o     = dbg_we_i & dbg_in_range;
      end else if (fetch_gnt_o) begin
         mem_addr_o   = fetch_addr_i;
         gnt_in_range = fetch_in_range;
      end
   end

   assign mem_en_o = (dbg_gnt_o | fetch_gnt_o) & gnt_in_range;

   always_comb begin
      rsp_tag_d = TAG_NONE;
      rsp_err_d = 1'b0;
      rsp_rd_d  = 1'b0;
      if (dbg_gnt_o) begin
         rsp_tag_d = TAG_DBG;
         rsp_err_d = ~dbg_in_range;
         rsp_rd_d  = ~dbg_we_i;
      end else if (fetch_gnt_o) begin
         rsp_tag_d = TAG_FETCH;
         rsp_err_d = ~fetch_in_range;
      end
   end

   // Response side: mem_rdata arrives the cycle after the grant, so steer it straight out and
   // remember it so the data outputs hold between valid pulses.
   assign fetch_valid_o = (rsp_tag_q == TAG_FETCH);
   assign dbg_valid_o   = (rsp_tag_q == TAG_DBG);
   assign rsp_err_o     = (fetch_valid_o | dbg_valid_o) & rsp_err_q;

   always_comb begin
      fetch_inst_o = fetch_hold_q;
      dbg_rdata_o  = dbg_hold_q;
      if (fetch_valid_o) fetch_inst_o = rsp_err_q ? 32'h0 : mem_rdata_i;
      if (dbg_valid_o)   dbg_rdata_o  = (rsp_rd_q && !rsp_err_q) ? mem_rdata_i : 32'h0;
   end

   assign fetch_hold_d = fetch_inst_o;
   assign dbg_hold_d   = dbg_rdata_o;

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         starve_cnt_q <= '0;
         rsp_tag_q    <= TAG_NONE;
         rsp_err_q    <= 1'b0;
         rsp_rd_q     <= 1'b0;
         fetch_hold_q <= '0;
         dbg_hold_q   <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         rsp_tag_q    <= rsp_tag_d;
         rsp_err_q    <= rsp_err_d;
         rsp_rd_q     <= rsp_rd_d;
         fetch_hold_q <= fetch_hold_d;
         dbg_hold_q   <= dbg_hold_d;
      end
   end

`ifdef IMEM_ARB_STATS_EN
   logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
   logic [CNT_W-1:0] dbg_cnt_q, dbg_cnt_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      return (en && v != '1) ? v + CNT_W'(1) : v;
   endfunction

   // Errors are counted when their response is delivered.
   assign fetch_cnt_d = sat_inc(fetch_cnt_q, fetch_gnt_o);
   assign dbg_cnt_d   = sat_inc(dbg_cnt_q, dbg_gnt_o);
   assign err_cnt_d   = sat_inc(err_cnt_q, rsp_err_o);

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         fetch_cnt_q <= '0;
         dbg_cnt_q   <= '0;
         err_cnt_q   <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         dbg_cnt_q   <= dbg_cnt_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign fetch_cnt_o = fetch_cnt_q;
   assign dbg_cnt_o   = dbg_cnt_q;
   assign err_cnt_o   = err_cnt_q;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: behavioural memory, response scoreboard, directed arbitration cases.
module tb_imem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_req, fetch_gnt, fetch_valid;
   logic [31:0] fetch_addr, fetch_inst;
   logic        dbg_req, dbg_we, dbg_halt, dbg_gnt, dbg_valid;
   logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
   logic        rsp_err, mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = 32'h0;
`ifdef IMEM_ARB_STATS_EN
   logic [15:0] fetch_cnt, dbg_cnt, err_cnt;
`endif

   imem_arbiter #(.DEPTH(128), .STARVE_LIMIT(4), .CNT_W(16)) dut (
      .clock_i(clk), .reset_i(rst),
      .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_gnt_o(fetch_gnt),
      .fetch_valid_o(fetch_valid), .fetch_inst_o(fetch_inst),
      .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
      .dbg_halt_i(dbg_halt), .dbg_gnt_o(dbg_gnt), .dbg_valid_o(dbg_valid), .dbg_rdata_o(dbg_rdata),
      .rsp_err_o(rsp_err), .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
`ifdef IMEM_ARB_STATS_EN
      , .fetch_cnt_o(fetch_cnt), .dbg_cnt_o(dbg_cnt), .err_cnt_o(err_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Memory: synchronous single port, read data registered one cycle after mem_en.
   logic [31:0] mem     [0:127];
   logic [31:0] ref_mem [0:127];

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr[8:2]] <= mem_wdata;
         mem_rdata <= mem[mem_addr[8:2]];
      end
   end

   typedef struct {
      logic        dbg;
      logic [31:0] data;
      logic        err;
   } rsp_t;

   rsp_t        sb[$];
   rsp_t        r_pop, r_push;
   logic [29:0] ix;
   logic        inr;

   // Scoreboard: pop/compare responses first, then record expectations for this cycle's grant.
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
      end else begin
         if (fetch_valid || dbg_valid) begin
            chk("dual_valid", {31'h0, fetch_valid & dbg_valid}, 32'h0);
            if (sb.size() == 0) begin
               chk("unexpected_rsp", {31'h0, fetch_valid | dbg_valid}, 32'h0);
            end else begin
               r_pop = sb.pop_front();
               chk("rsp_kind", {31'h0, dbg_valid}, {31'h0, r_pop.dbg});
               chk("rsp_data", r_pop.dbg ? dbg_rdata : fetch_inst, r_pop.data);
               chk("rsp_err", {31'h0, rsp_err}, {31'h0, r_pop.err});
            end
         end
         if (fetch_gnt || dbg_gnt) begin
            chk("dual_gnt", {31'h0, fetch_gnt & dbg_gnt}, 32'h0);
            ix  = dbg_gnt ? dbg_addr[31:2] : fetch_addr[31:2];
            inr = (ix < 30'd128);
            chk("gnt_mem_en", {31'h0, mem_en}, {31'h0, inr});
            r_push.dbg = dbg_gnt;
            r_push.err = ~inr;
            if (dbg_gnt && dbg_we) begin
               r_push.data = 32'h0;
               if (inr) ref_mem[ix[6:0]] = dbg_wdata;
            end else begin
               r_push.data = inr ? ref_mem[ix[6:0]] : 32'h0;
            end
            sb.push_back(r_push);
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 128; i++) begin
         mem[i]     = $urandom;
         ref_mem[i] = mem[i];
      end
      rst = 1'b1;
      fetch_req = 1'b1; fetch_addr = 32'h0;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h4; dbg_wdata = 32'h0; dbg_halt = 1'b0;

      // Reset: requests present but nothing may be granted or returned.
      @(negedge clk);
      chk("rst_fetch_gnt", {31'h0, fetch_gnt}, 32'h0);
      chk("rst_dbg_gnt", {31'h0, dbg_gnt}, 32'h0);
      chk("rst_mem_en", {31'h0, mem_en}, 32'h0);
      chk("rst_valids", {30'h0, fetch_valid, dbg_valid}, 32'h0);
      chk("rst_err", {31'h0, rsp_err}, 32'h0);
      chk("rst_fetch_inst", fetch_inst, 32'h0);
      chk("rst_dbg_rdata", dbg_rdata, 32'h0);
      next_cycle();
      rst = 1'b0; fetch_req = 1'b0; dbg_req = 1'b0;

      // 1: back-to-back fetches
      for (int i = 0; i < 3; i++) begin
         fetch_req = 1'b1; fetch_addr = 32'(i * 4);
         @(negedge clk);
         chk("t1_fetch_gnt", {31'h0, fetch_gnt}, 32'h1);
         next_cycle();
      end
      fetch_req = 1'b0;
      @(negedge clk);
      chk("t1_last_valid", {31'h0, fetch_valid}, 32'h1);
      chk("t1_last_inst", fetch_inst, ref_mem[2]);
      next_cycle();
      @(negedge clk);
      chk("t1_valid_pulse", {31'h0, fetch_valid}, 32'h0);
      chk("t1_inst_hold", fetch_inst, ref_mem[2]);
      next_cycle();

      // 2: anti-starvation, debug wins on the 5th contended cycle
      fetch_req = 1'b1; fetch_addr = 32'h40;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h10;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         chk("t2_dbg_denied", {31'h0, dbg_gnt}, 32'h0);
         chk("t2_fetch_gnt", {31'h0, fetch_gnt}, 32'h1);
         next_cycle();
      end
      @(negedge clk);
      chk("t2_dbg_forced", {31'h0, dbg_gnt}, 32'h1);
      chk("t2_fetch_stall", {31'h0, fetch_gnt}, 32'h0);
      chk("t2_mem_addr", mem_addr, 32'h10);
      next_cycle();
      dbg_req = 1'b0; fetch_req = 1'b0;
      @(negedge clk);
      chk("t2_dbg_valid", {31'h0, dbg_valid}, 32'h1);
      chk("t2_dbg_rdata", dbg_rdata, ref_mem[4]);
      next_cycle();

      // 3: halt with a fetch in flight, then debug write/read
      fetch_req = 1'b1; fetch_addr = 32'h8;
      @(negedge clk);
      chk("t3_fetch_gnt", {31'h0, fetch_gnt}, 32'h1);
      next_cycle();
      dbg_halt = 1'b1; dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h20; dbg_wdata = 32'hDEADBEEF;
      @(negedge clk);
      chk("t3_inflight_valid", {31'h0, fetch_valid}, 32'h1);
      chk("t3_halt_no_fetch", {31'h0, fetch_gnt}, 32'h0);
      chk("t3_wr_gnt", {31'h0, dbg_gnt}, 32'h1);
      chk("t3_mem_we", {31'h0, mem_we}, 32'h1);
      chk("t3_mem_wdata", mem_wdata, 32'hDEADBEEF);
      next_cycle();
      dbg_we = 1'b0;
      @(negedge clk);
      chk("t3_rd_gnt", {31'h0, dbg_gnt}, 32'h1);
      chk("t3_rd_no_we", {31'h0, mem_we}, 32'h0);
      chk("t3_wr_rsp", dbg_rdata, 32'h0);
      next_cycle();
      dbg_req = 1'b0;
      @(negedge clk);
      chk("t3_rd_valid", {31'h0, dbg_valid}, 32'h1);
      chk("t3_rd_data", dbg_rdata, 32'hDEADBEEF);
      chk("t3_halt_no_fetch2", {31'h0, fetch_gnt}, 32'h0);
      next_cycle();
      dbg_halt = 1'b0; fetch_req = 1'b0;

      // 4: misaligned (no error) and out-of-range fetches
      fetch_req = 1'b1; fetch_addr = 32'h0E;
      next_cycle();
      fetch_addr = 32'h200;
      @(negedge clk);
      chk("t4_misalign_inst", fetch_inst, ref_mem[3]);
      chk("t4_misalign_err", {31'h0, rsp_err}, 32'h0);
      chk("t4_oor_gnt", {31'h0, fetch_gnt}, 32'h1);
      chk("t4_oor_no_mem", {31'h0, mem_en}, 32'h0);
      next_cycle();
      fetch_req = 1'b0;
      @(negedge clk);
      chk("t4_oor_valid", {31'h0, fetch_valid}, 32'h1);
      chk("t4_oor_err", {31'h0, rsp_err}, 32'h1);
      chk("t4_oor_inst", fetch_inst, 32'h0);
      next_cycle();

      // 5: reset right after a grant drops the response
      fetch_req = 1'b1; fetch_addr = 32'h4;
      @(negedge clk);
      chk("t5_gnt", {31'h0, fetch_gnt}, 32'h1);
      next_cycle();
      rst = 1'b1; fetch_req = 1'b0;
      @(negedge clk);
      chk("t5_rst_valids", {30'h0, fetch_valid, dbg_valid}, 32'h0);
      chk("t5_rst_inst", fetch_inst, 32'h0);
      chk("t5_rst_rdata", dbg_rdata, 32'h0);
      chk("t5_rst_err", {31'h0, rsp_err}, 32'h0);
      next_cycle();
      rst = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("t5_no_late_valid", {30'h0, fetch_valid, dbg_valid}, 32'h0);
         next_cycle();
      end

      // 6: traffic for the statistics counters: 3 fetches (one error), 1 debug read
      fetch_req = 1'b1; fetch_addr = 32'h0;
      next_cycle();
      fetch_addr = 32'h4;
      next_cycle();
      fetch_addr = 32'h200;
      next_cycle();
      fetch_req = 1'b0; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h8;
      next_cycle();
      dbg_req = 1'b0;
      next_cycle();
      next_cycle();
`ifdef IMEM_ARB_STATS_EN
      @(negedge clk);
      chk("t6_fetch_cnt", {16'h0, fetch_cnt}, 32'd3);
      chk("t6_dbg_cnt", {16'h0, dbg_cnt}, 32'd1);
      chk("t6_err_cnt", {16'h0, err_cnt}, 32'd1);
`endif
      @(negedge clk);
      chk("sb_drained", 32'(sb.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
